alu_pipe_dsp: RTL

//  Parametrised, pipelined successor to the sail-core combinational ALU. It accepts one operation
//  per cycle under a valid/ready handshake and returns results in order through a LATENCY-stage pipe.
//  It also produces the branch decision. An iterative unsigned multiplier (MUL/MULHU) is added as a

---
 rtl/alu_pipe_dsp.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/alu_pipe_dsp.sv
// Pipelined ALU with branch decision and an iterative unsigned multiplier sharing the output register.
// Results leave in acceptance order through a LATENCY-stage pipe under valid/ready handshakes.
module alu_pipe_dsp #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned LATENCY  = 2,
   parameter int unsigned MUL_BITS = 8,
   parameter int unsigned TAG_W    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             branch_enable,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned SH_W      = $clog2(WIDTH);
   localparam int unsigned ACC_W     = 2 * WIDTH;
   localparam int unsigned MUL_STEPS = WIDTH / MUL_BITS;
   localparam int unsigned CNT_W     = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
   // Stages ahead of the output register, and those that are still ahead of it one edge later
   localparam logic [LATENCY-1:0] INNER_MASK = LATENCY'((1 << (LATENCY - 1)) - 1);
   localparam logic [LATENCY-1:0] PRE_MASK   = INNER_MASK >> 1;

   localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB   = 4'd1,  OP_AND  = 4'd2,  OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4,  OP_SLL   = 4'd5,  OP_SRL  = 4'd6,  OP_SRA = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8,  OP_SLTU  = 4'd9,  OP_MUL  = 4'd10, OP_MULHU = 4'd11;
   localparam logic [3:0] OP_BEQ  = 4'd12, OP_BNE   = 4'd13, OP_BLT  = 4'd14, OP_BGE = 4'd15;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             br;
      logic [TAG_W-1:0] tag;
   } stage_t;

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_MUL, S_LOAD} state_t;

   state_t             state;
   logic [LATENCY-1:0] stg_vld;
   stage_t             stg [LATENCY];
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CNT_W-1:0]   cnt;
   logic               mul_hi;
   logic [TAG_W-1:0]   mul_tag;

   logic               stall;
   logic               accept;
   logic               is_mul;
   logic [WIDTH-1:0]   diff;
   logic [SH_W-1:0]    shamt;
   stage_t             alu_out;
   stage_t             mul_out;

   assign out_valid     = stg_vld[LATENCY-1];
   assign result        = stg[LATENCY-1].res;
   assign branch_enable = stg[LATENCY-1].br;
   assign out_tag       = stg[LATENCY-1].tag;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = (state == S_IDLE) & ~stall;
   assign accept   = in_valid & in_ready;
   assign is_mul   = (op == OP_MUL) | (op == OP_MULHU);
   assign diff     = a - b;
   assign shamt    = b[SH_W-1:0];

   // Single-cycle operations evaluated on the way into stage 0
   always_comb begin
      alu_out     = '0;
      alu_out.tag = in_tag;
      case (op)
         OP_ADD:  alu_out.res = a + b;
         OP_SUB:  alu_out.res = diff;
         OP_AND:  alu_out.res = a & b;
         OP_OR:   alu_out.res = a | b;
         OP_XOR:  alu_out.res = a ^ b;
         OP_SLL:  alu_out.res = a << shamt;
         OP_SRL:  alu_out.res = a >> shamt;
         OP_SRA:  alu_out.res = WIDTH'($signed(a) >>> shamt);
         OP_SLT:  alu_out.res = WIDTH'($signed(a) < $signed(b));
         OP_SLTU: alu_out.res = WIDTH'(a < b);
         OP_BEQ:  begin alu_out.res = diff; alu_out.br = (a == b); end
         OP_BNE:  begin alu_out.res = diff; alu_out.br = (a != b); end
         OP_BLT:  begin alu_out.res = diff; alu_out.br = ($signed(a) < $signed(b)); end
         OP_BGE:  begin alu_out.res = diff; alu_out.br = ($signed(a) >= $signed(b)); end
         default: alu_out.res = '0;
      endcase
   end

   always_comb begin
      mul_out     = '0;
      mul_out.res = mul_hi ? acc[ACC_W-1:WIDTH] : acc[WIDTH-1:0];
      mul_out.tag = mul_tag;
   end

   // Result pipe; the multiplier claims the output register in LOAD (inner stages are empty then)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stg_vld <= '0;
         for (int unsigned i = 0; i < LATENCY; i++) stg[i] <= '0;
      end else if (!stall) begin
         stg_vld[0] <= accept & ~is_mul;
         stg[0]     <= alu_out;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            stg_vld[i] <= stg_vld[i-1];
            stg[i]     <= stg[i-1];
         end
         if (state == S_LOAD) begin
            stg_vld[LATENCY-1] <= 1'b1;
            stg[LATENCY-1]     <= mul_out;
         end
      end
   end

   // Multiplier control: DRAIN is skipped when the pipe is already empty after the accepting edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         mul_hi  <= 1'b0;
         mul_tag <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept && is_mul) begin
                  mcand   <= ACC_W'(a);
                  mplier  <= b;
                  acc     <= '0;
                  cnt     <= '0;
                  mul_hi  <= (op == OP_MULHU);
                  mul_tag <= in_tag;
                  state   <= ((stg_vld & PRE_MASK) == '0) ? S_MUL : S_DRAIN;
               end
            end
            S_DRAIN: begin
               if ((stg_vld & INNER_MASK) == '0) state <= S_MUL;
            end
            S_MUL: begin
               acc    <= acc + mcand * ACC_W'(mplier[MUL_BITS-1:0]);
               mcand  <= mcand << MUL_BITS;
               mplier <= mplier >> MUL_BITS;
               cnt    <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(MUL_STEPS - 1)) state <= S_LOAD;
            end
            S_LOAD: begin
               if (!stall) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
